// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared widths, timeout default and MEM-stage FSM state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int c_REG_ADDR_W      = 5;
   localparam int c_DATA_W          = 32;
   localparam int c_TIMEOUT_DEFAULT = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_if : data-memory request/acknowledge bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_access_if;
   import cpu_pkg::*;

   logic                dmem_req_o;
   logic                dmem_we_o;
   logic [c_DATA_W-1:0] dmem_addr_o;
   logic [c_DATA_W-1:0] dmem_wdata_o;
   logic                dmem_ack_i;
   logic [c_DATA_W-1:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_ack_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      output dmem_ack_i, dmem_rdata_i
   );

endinterface
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_reg : MEM/WB pipeline register with bubble insertion on stall
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_wb_reg
   import cpu_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    stall,
   input  logic                    RegWrite_i,
   input  logic                    MemReg_i,
   input  logic [c_REG_ADDR_W-1:0] rd_addr_i,
   input  logic [c_DATA_W-1:0]     ALUResult_i,
   input  logic [c_DATA_W-1:0]     ReadData_i,
   output logic                    RegWrite_o,
   output logic                    MemReg_o,
   output logic [c_REG_ADDR_W-1:0] rd_addr_o,
   output logic [c_DATA_W-1:0]     ALUResult_o,
   output logic [c_DATA_W-1:0]     ReadData_o,
   output logic [c_DATA_W-1:0]     WBData_o
);

   logic                    r_reg_write;
   logic                    r_mem_reg;
   logic [c_REG_ADDR_W-1:0] r_rd_addr;
   logic [c_DATA_W-1:0]     r_alu_result;
   logic [c_DATA_W-1:0]     r_read_data;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_reg_write  <= 1'b0;
         r_mem_reg    <= 1'b0;
         r_rd_addr    <= '0;
         r_alu_result <= '0;
         r_read_data  <= '0;
      end else if (stall) begin
         // Bubble: kill the write-back controls, keep the data fields
         r_reg_write  <= 1'b0;
         r_mem_reg    <= 1'b0;
      end else begin
         r_reg_write  <= RegWrite_i;
         r_mem_reg    <= MemReg_i;
         r_rd_addr    <= rd_addr_i;
         r_alu_result <= ALUResult_i;
         r_read_data  <= ReadData_i;
      end
   end

   assign RegWrite_o  = r_reg_write;
   assign MemReg_o    = r_mem_reg;
   assign rd_addr_o   = r_rd_addr;
   assign ALUResult_o = r_alu_result;
   assign ReadData_o  = r_read_data;
   assign WBData_o    = r_mem_reg ? r_read_data : r_alu_result;

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access : MEM stage - data-memory access FSM with timeout, stall and MEM/WB
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_access
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    RegWrite_i,
   input  logic                    MemReg_i,
   input  logic                    MemRead_i,
   input  logic                    MemWrite_i,
   input  logic [c_DATA_W-1:0]     ALUResult_i,
   input  logic [c_DATA_W-1:0]     MemData_i,
   input  logic [c_REG_ADDR_W-1:0] rd_addr_i,
   mem_access_if.master            dmem,
   output logic                    stall_o,
   output logic                    RegWrite_o,
   output logic                    MemReg_o,
   output logic [c_REG_ADDR_W-1:0] rd_addr_o,
   output logic [c_DATA_W-1:0]     ALUResult_o,
   output logic [c_DATA_W-1:0]     ReadData_o,
   output logic [c_DATA_W-1:0]     WBData_o,
   output logic                    err_o
);

   localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_count;
   logic                r_req;
   logic                r_we;
   logic                r_err;
   logic [c_DATA_W-1:0] r_addr;
   logic [c_DATA_W-1:0] r_wdata;

   logic                w_mem_op;
   logic                w_misaligned;
   logic                w_wait;
   logic                w_start;
   logic                w_bad_op;
   logic                w_timeout_hit;
   logic                w_done;
   logic                w_stall;
   logic [c_DATA_W-1:0] w_read_data;

   assign w_mem_op      = MemRead_i | MemWrite_i;
   assign w_misaligned  = (ALUResult_i[1:0] != 2'b00);
   assign w_wait        = (r_state == ST_WAIT);
   assign w_start       = !w_wait & w_mem_op & !w_misaligned;
   assign w_bad_op      = !w_wait & w_mem_op & w_misaligned;
   assign w_timeout_hit = w_wait & (r_count == c_CNT_W'(TIMEOUT - 1)) & !dmem.dmem_ack_i;
   assign w_done        = w_wait & (dmem.dmem_ack_i | w_timeout_hit);
   assign w_stall       = rst_i & (w_start | (w_wait & !w_done));
   // Writes and timeouts complete with zero read data; acks outside WAIT never matter
   assign w_read_data   = (w_wait & dmem.dmem_ack_i & !r_we) ? dmem.dmem_rdata_i : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_timeout_hit | w_bad_op;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state <= ST_WAIT;
                  r_count <= '0;
                  r_req   <= 1'b1;
                  r_we    <= MemWrite_i;
                  r_addr  <= ALUResult_i;
                  r_wdata <= MemData_i;
               end
            end
            ST_WAIT: begin
               if (w_done) begin
                  r_state <= ST_IDLE;
                  r_req   <= 1'b0;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stall_o           = w_stall;
   assign err_o             = r_err;
   assign dmem.dmem_req_o   = r_req;
   assign dmem.dmem_we_o    = r_we;
   assign dmem.dmem_addr_o  = r_addr;
   assign dmem.dmem_wdata_o = r_wdata;

   mem_wb_reg u_mem_wb_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .stall       (w_stall),
      .RegWrite_i  (RegWrite_i),
      .MemReg_i    (MemReg_i),
      .rd_addr_i   (rd_addr_i),
      .ALUResult_i (ALUResult_i),
      .ReadData_i  (w_read_data),
      .RegWrite_o  (RegWrite_o),
      .MemReg_o    (MemReg_o),
      .rd_addr_o   (rd_addr_o),
      .ALUResult_o (ALUResult_o),
      .ReadData_o  (ReadData_o),
      .WBData_o    (WBData_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_access : randomized MEM-stage bench against a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_access;

   localparam int TMO = 16;

   typedef struct {
      logic        rw, mr, rd_en, wr_en;
      logic [31:0] alu, wdata, rdata;
      logic [4:0]  rd;
      int          ack_at;   // WAIT cycle (1-based) on which memory acks
   } op_t;

   typedef struct {
      logic        rw, mr;
      logic [4:0]  rd;
      logic [31:0] alu, rdata;
      logic        known, err;
   } wb_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        RegWrite_i, MemReg_i, MemRead_i, MemWrite_i;
   logic [31:0] ALUResult_i, MemData_i;
   logic [4:0]  rd_addr_i;
   logic        stall_o, RegWrite_o, MemReg_o, err_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] ALUResult_o, ReadData_o, WBData_o;

   mem_access_if dmem_bus ();

   mem_access #(.TIMEOUT(TMO)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .RegWrite_i  (RegWrite_i),
      .MemReg_i    (MemReg_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .ALUResult_i (ALUResult_i),
      .MemData_i   (MemData_i),
      .rd_addr_i   (rd_addr_i),
      .dmem        (dmem_bus),
      .stall_o     (stall_o),
      .RegWrite_o  (RegWrite_o),
      .MemReg_o    (MemReg_o),
      .rd_addr_o   (rd_addr_o),
      .ALUResult_o (ALUResult_o),
      .ReadData_o  (ReadData_o),
      .WBData_o    (WBData_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_errors = 0;
   int          stall_seen = 0;
   int          req_seen = 0;
   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_bus_chk, exp_we;
   logic [31:0] exp_addr, exp_wdata;
   wb_t         exp_wb;
   logic        last_we;
   logic [31:0] last_addr, last_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_wb_zero(input logic known);
      exp_wb.rw = 1'b0; exp_wb.mr = 1'b0; exp_wb.rd = '0; exp_wb.alu = '0;
      exp_wb.rdata = '0; exp_wb.known = known; exp_wb.err = 1'b0;
   endtask

   task automatic drive(input op_t op);
      RegWrite_i = op.rw;  MemReg_i = op.mr;  MemRead_i = op.rd_en;  MemWrite_i = op.wr_en;
      ALUResult_i = op.alu; MemData_i = op.wdata; rd_addr_i = op.rd;
   endtask

   function automatic op_t mk_op(input logic rw, input logic mr, input logic rd_en, input logic wr_en,
                                 input logic [31:0] alu, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic [4:0] rd, input int ack_at);
      op_t op;
      op.rw = rw; op.mr = mr; op.rd_en = rd_en; op.wr_en = wr_en;
      op.alu = alu; op.wdata = wdata; op.rdata = rdata; op.rd = rd; op.ack_at = ack_at;
      return op;
   endfunction

   function automatic op_t rand_op();
      op_t op;
      int  sel;
      sel = int'($urandom_range(0, 99));
      op = mk_op(1'($urandom), 1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom, 5'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TMO + 3)) : int'($urandom_range(1, 3)));
      if (sel >= 35 && sel < 65) begin
         op.rd_en = 1'b1; op.mr = 1'($urandom);
      end else if (sel >= 65 && sel < 90) begin
         op.wr_en = 1'b1;
      end else if (sel >= 90) begin
         op.rd_en = 1'b1; op.wr_en = 1'b1;
      end
      if (sel >= 35 && $urandom_range(0, 4) != 0) op.alu[1:0] = 2'b00;
      return op;
   endfunction

   // Transaction-level model: an aligned memory op stalls min(ack_at, TMO) cycles,
   // everything else passes in one cycle; MEM/WB shows the op after its last cycle.
   task automatic run_op(input op_t op);
      logic mem_op, ok, acked;
      int   s;
      mem_op = op.rd_en | op.wr_en;
      ok     = mem_op && (op.alu[1:0] == 2'b00);
      acked  = ok && (op.ack_at <= TMO);
      s      = !ok ? 0 : (acked ? op.ack_at : TMO);
      drive(op);
      for (int k = 0; k <= s; k++) begin
         dmem_bus.dmem_ack_i   = (k == 0) ? 1'($urandom) : (acked && k == s);
         dmem_bus.dmem_rdata_i = dmem_bus.dmem_ack_i ? op.rdata : $urandom;
         exp_stall   = (k < s);
         exp_req     = ok && (k >= 1);
         exp_bus_chk = exp_req;
         exp_addr    = op.alu;
         exp_we      = op.wr_en;
         exp_wdata   = op.wdata;
         if (k == 1) begin
            exp_wb.rw = 1'b0; exp_wb.mr = 1'b0; exp_wb.err = 1'b0;
         end
         @(posedge clk_i); #1;
      end
      exp_wb.rw = op.rw; exp_wb.mr = op.mr; exp_wb.rd = op.rd; exp_wb.alu = op.alu;
      if (ok) begin
         exp_wb.rdata = (acked && !op.wr_en) ? op.rdata : 32'd0;
         exp_wb.known = 1'b1;
         exp_wb.err   = !acked;
      end else if (mem_op) begin
         exp_wb.rdata = 32'd0; exp_wb.known = 1'b1; exp_wb.err = 1'b1;
      end else begin
         exp_wb.known = 1'b0; exp_wb.err = 1'b0;
      end
   endtask

   // Per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk_i);
         if (chk_en) begin
            if (stall_o) stall_seen++;
            if (dmem_bus.dmem_req_o) begin
               req_seen++;
               last_we    = dmem_bus.dmem_we_o;
               last_addr  = dmem_bus.dmem_addr_o;
               last_wdata = dmem_bus.dmem_wdata_o;
            end
            chk("stall_o", 32'(stall_o), 32'(exp_stall));
            chk("dmem_req_o", 32'(dmem_bus.dmem_req_o), 32'(exp_req));
            if (exp_bus_chk) begin
               chk("dmem_we_o", 32'(dmem_bus.dmem_we_o), 32'(exp_we));
               chk("dmem_addr_o", dmem_bus.dmem_addr_o, exp_addr);
               chk("dmem_wdata_o", dmem_bus.dmem_wdata_o, exp_wdata);
            end
            chk("RegWrite_o", 32'(RegWrite_o), 32'(exp_wb.rw));
            chk("MemReg_o", 32'(MemReg_o), 32'(exp_wb.mr));
            chk("rd_addr_o", 32'(rd_addr_o), 32'(exp_wb.rd));
            chk("ALUResult_o", ALUResult_o, exp_wb.alu);
            chk("err_o", 32'(err_o), 32'(exp_wb.err));
            if (exp_wb.known) chk("ReadData_o", ReadData_o, exp_wb.rdata);
            if (!exp_wb.mr) chk("WBData_o", WBData_o, exp_wb.alu);
            else if (exp_wb.known) chk("WBData_o", WBData_o, exp_wb.rdata);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0, r0;
      // Reset with a load presented: stall must stay low, everything zero
      rst_i = 1'b0;
      drive(mk_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd1, 1));
      dmem_bus.dmem_ack_i = 1'b0; dmem_bus.dmem_rdata_i = '0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_bus_chk = 1'b1;
      exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      set_wb_zero(1'b1);
      @(posedge clk_i); #1;
      chk_en = 1'b1;
      repeat (2) begin @(posedge clk_i); #1; end
      rst_i = 1'b1;

      // Load, ack on 3rd WAIT cycle
      s0 = stall_seen;
      run_op(mk_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd9, 3));
      chk("load_stall_cycles", 32'(stall_seen - s0), 32'd3);
      chk("load_readdata", ReadData_o, 32'hDEADBEEF);
      chk("load_wbdata", WBData_o, 32'hDEADBEEF);
      chk("load_regwrite", 32'(RegWrite_o), 32'd1);

      // Store, ack on 1st WAIT cycle
      s0 = stall_seen;
      run_op(mk_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678, 32'h0, 5'd0, 1));
      chk("store_stall_cycles", 32'(stall_seen - s0), 32'd1);
      chk("store_we", 32'(last_we), 32'd1);
      chk("store_addr", last_addr, 32'h40);
      chk("store_wdata", last_wdata, 32'h12345678);
      chk("store_regwrite", 32'(RegWrite_o), 32'd0);

      // ALU op passes straight through
      s0 = stall_seen;
      run_op(mk_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0, 5'd5, 1));
      chk("alu_stall_cycles", 32'(stall_seen - s0), 32'd0);
      chk("alu_rd_addr", 32'(rd_addr_o), 32'd5);
      chk("alu_wbdata", WBData_o, 32'h7);

      // Load with no ack: timeout
      s0 = stall_seen;
      run_op(mk_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'hFFFFFFFF, 5'd4, TMO + 10));
      chk("timeout_stall_cycles", 32'(stall_seen - s0), 32'd16);
      chk("timeout_err", 32'(err_o), 32'd1);
      chk("timeout_readdata", ReadData_o, 32'd0);

      // Misaligned load
      s0 = stall_seen; r0 = req_seen;
      run_op(mk_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 32'hAAAA5555, 5'd6, 1));
      chk("misaligned_stall_cycles", 32'(stall_seen - s0), 32'd0);
      chk("misaligned_req_cycles", 32'(req_seen - r0), 32'd0);
      chk("misaligned_err", 32'(err_o), 32'd1);
      chk("misaligned_readdata", ReadData_o, 32'd0);

      // Reset on the 2nd WAIT cycle of a load, then a late ack
      drive(mk_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h55, 32'h0, 5'd3, 1));
      dmem_bus.dmem_ack_i = 1'b0;
      exp_stall = 1'b1; exp_req = 1'b0; exp_bus_chk = 1'b0;
      @(posedge clk_i); #1;
      exp_req = 1'b1; exp_bus_chk = 1'b1; exp_addr = 32'h300; exp_we = 1'b0; exp_wdata = 32'h55;
      exp_wb.rw = 1'b0; exp_wb.mr = 1'b0; exp_wb.err = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0; exp_stall = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      drive(mk_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1));
      dmem_bus.dmem_ack_i = 1'b1; dmem_bus.dmem_rdata_i = 32'hCAFEF00D;
      exp_req = 1'b0; exp_bus_chk = 1'b1; exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
      set_wb_zero(1'b1);
      chk("rst_wait_req", 32'(dmem_bus.dmem_req_o), 32'd0);
      chk("rst_wait_readdata", ReadData_o, 32'd0);
      chk("rst_wait_regwrite", 32'(RegWrite_o), 32'd0);
      @(posedge clk_i); #1;
      dmem_bus.dmem_ack_i = 1'b0;
      set_wb_zero(1'b0);
      chk("late_ack_req", 32'(dmem_bus.dmem_req_o), 32'd0);
      chk("late_ack_err", 32'(err_o), 32'd0);

      // Randomized traffic
      repeat (200) run_op(rand_op());
      run_op(mk_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1));
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent in WAIT before the access is aborted.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have EX/MEM control inputs RegWrite_i, MemReg_i, MemRead_i and MemWrite_i, each input, 1 bit.
REQ-005 SHALL have inputs ALUResult_i (32 bits, address or result), MemData_i (32 bits, store data) and rd_addr_i (5 bits, destination register).
REQ-006 SHALL have data-memory outputs dmem_req_o (1), dmem_we_o (1), dmem_addr_o (32) and dmem_wdata_o (32).
REQ-007 SHALL have data-memory inputs dmem_ack_i (1 bit, one-cycle completion strobe) and dmem_rdata_i (32 bits, valid with ack).
REQ-008 SHALL have output stall_o, 1 bit: holds PC, IF/ID, ID/EX and EX/MEM.
REQ-009 SHALL have MEM/WB outputs RegWrite_o (1), MemReg_o (1), rd_addr_o (5), ALUResult_o (32), ReadData_o (32), WBData_o (32) and err_o (1).

Function
REQ-010 SHALL run an FSM with two states: IDLE and WAIT.
REQ-011 mem_op SHALL equal MemRead_i OR MemWrite_i; misaligned SHALL equal ALUResult_i[1:0] != 0.
REQ-012 In IDLE with mem_op and aligned: stall_o=1 combinationally; next state WAIT; dmem_req_o=1 registered; latch addr=ALUResult_i, wdata=MemData_i, we=MemWrite_i.
REQ-013 When MemRead_i and MemWrite_i are both 1, the access SHALL be a write, and ReadData_o SHALL be 0.
REQ-014 In WAIT: stall_o = NOT dmem_ack_i AND NOT timeout_hit; dmem_req_o and the latched addr/wdata/we SHALL stay stable.
REQ-015 On dmem_ack_i in WAIT: the same edge captures dmem_rdata_i into ReadData_o (reads) or 0 (writes); dmem_req_o drops; state goes to IDLE.
REQ-016 The wait counter SHALL clear on WAIT entry and increment each WAIT cycle; timeout_hit = (count == TIMEOUT-1) AND NOT ack.
REQ-017 On timeout_hit: complete as if acked with ReadData_o=0; err_o=1 for one cycle; state goes to IDLE.
REQ-018 In IDLE with mem_op and misaligned: no request and no stall; loads give ReadData_o=0, stores are dropped; err_o pulses 1 the following cycle.
REQ-019 Non-memory ops SHALL pass to MEM/WB in one cycle with no stall.
REQ-020 dmem_ack_i in IDLE SHALL be ignored.
REQ-021 When stall_o=0, the MEM/WB register SHALL latch RegWrite, MemReg, rd_addr and ALUResult from the inputs.
REQ-022 When stall_o=1, the block SHALL insert a bubble: RegWrite_o=0 and MemReg_o=0, with the other fields held.
REQ-023 WBData_o SHALL be combinational: MemReg_o ? ReadData_o : ALUResult_o.
REQ-024 Minimum memory-op latency SHALL be 2 cycles (a 1-cycle stall with ack on the first WAIT cycle); the maximum stall SHALL be TIMEOUT cycles.
REQ-025 The EX/MEM inputs are held stable by upstream while stall_o=1; the block SHALL NOT re-issue a request for the same op after completion.

Reset
REQ-026 With rst_i=0 at a clock edge: state=IDLE, counter=0, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0.
REQ-027 The same reset edge SHALL set all MEM/WB outputs to 0 and err_o to 0; stall_o SHALL be 0 while rst_i=0.
REQ-028 Reset during WAIT SHALL abandon the access; a late ack SHALL be ignored per REQ-020.

Structure
REQ-029 A shared package cpu_pkg SHALL hold the FSM state enum, the 5-bit register-address width, the 32-bit data width and the TIMEOUT default.
REQ-030 The MEM/WB register SHALL be a sub-module mem_wb_reg with inputs stall and rst_i; the FSM and counter SHALL stay in mem_access.

Verification
REQ-031 Load: MemRead=1, addr 0x100, ack on the 3rd WAIT cycle with rdata 0xDEADBEEF -> stall high for 3 cycles, then ReadData_o=0xDEADBEEF; with MemReg=1, WBData_o=0xDEADBEEF and RegWrite_o=1.
REQ-032 Store: MemWrite=1, addr 0x40, data 0x12345678, ack on the 1st WAIT cycle -> dmem_we_o=1, dmem_wdata_o=0x12345678, stall for 1 cycle, RegWrite_o=0.
REQ-033 ALU op: RegWrite=1, ALUResult 0x7, rd=5 -> the next cycle gives rd_addr_o=5 and WBData_o=0x7, with no stall.
REQ-034 Timeout: load with no ack -> stall for 16 cycles, err_o pulse, ReadData_o=0.
REQ-035 Misaligned load at 0x102 -> no dmem_req_o, no stall, err_o=1 the next cycle, ReadData_o=0.
REQ-036 rst_i=0 on the 2nd WAIT cycle, then ack -> IDLE, all outputs 0, ack ignored.
